// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Pong game sequencer. Runs the NEWGAME/PLAY/NEWBALL/OVER flow,
//             keeps the BCD score and balls-remaining count, and drives the
//             text-region enables and graphics freeze.
//  Options  : PONG_SCORE_SAT_EN - score saturates at 99 instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    input  logic       refr_tick,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic       graph_still,
    output logic [3:0] text_en
);

    localparam logic [1:0] c_balls       = 2'(BALLS);
    localparam logic [7:0] c_timer_ticks = 8'(TIMER_TICKS);

    localparam logic [1:0] c_st_newgame = 2'd0;
    localparam logic [1:0] c_st_play    = 2'd1;
    localparam logic [1:0] c_st_newball = 2'd2;
    localparam logic [1:0] c_st_over    = 2'd3;

    logic [1:0] r_state,       w_state_next;
    logic [3:0] r_dig0,        w_dig0_next;
    logic [3:0] r_dig1,        w_dig1_next;
    logic [1:0] r_ball,        w_ball_next;
    logic [7:0] r_timer,       w_timer_next;
    logic       r_graph_still, w_graph_still_next;
    logic [3:0] r_text_en,     w_text_en_next;

    always_comb begin
        w_state_next = r_state;
        w_dig0_next  = r_dig0;
        w_dig1_next  = r_dig1;
        w_ball_next  = r_ball;
        w_timer_next = (refr_tick && (r_timer != 8'd0)) ? r_timer - 8'd1 : r_timer;

        case (r_state)
            c_st_newgame: begin
                if (btn != 2'b00) begin
                    w_state_next = c_st_play;
                    w_dig0_next  = 4'd0;
                    w_dig1_next  = 4'd0;
                    w_ball_next  = c_balls;
                end
            end
            c_st_play: begin
                // A miss outranks a simultaneous hit and any same-cycle tick.
                if (miss) begin
                    w_timer_next = c_timer_ticks;
                    if (r_ball == 2'd1) begin
                        w_ball_next  = 2'd0;
                        w_state_next = c_st_over;
                    end else begin
                        w_ball_next  = r_ball - 2'd1;
                        w_state_next = c_st_newball;
                    end
                end else if (hit) begin
                    if (r_dig0 == 4'd9) begin
                        if (r_dig1 == 4'd9) begin
`ifdef PONG_SCORE_SAT_EN
                            w_dig0_next = 4'd9;
                            w_dig1_next = 4'd9;
`else
                            w_dig0_next = 4'd0;
                            w_dig1_next = 4'd0;
`endif
                        end else begin
                            w_dig0_next = 4'd0;
                            w_dig1_next = r_dig1 + 4'd1;
                        end
                    end else begin
                        w_dig0_next = r_dig0 + 4'd1;
                    end
                end
            end
            c_st_newball: begin
                if ((r_timer == 8'd0) && (btn != 2'b00)) begin
                    w_state_next = c_st_play;
                end
            end
            c_st_over: begin
                // Score is left untouched so the final result stays on screen.
                if (r_timer == 8'd0) begin
                    w_state_next = c_st_newgame;
                    w_ball_next  = c_balls;
                end
            end
            default: begin
                w_state_next = c_st_newgame;
            end
        endcase

        w_graph_still_next = (w_state_next != c_st_play);
        case (w_state_next)
            c_st_newgame: w_text_en_next = 4'b1110;
            c_st_over:    w_text_en_next = 4'b1001;
            default:      w_text_en_next = 4'b1000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_st_newgame;
            r_dig0        <= 4'd0;
            r_dig1        <= 4'd0;
            r_ball        <= c_balls;
            r_timer       <= 8'd0;
            r_graph_still <= 1'b1;
            r_text_en     <= 4'b1110;
        end else begin
            r_state       <= w_state_next;
            r_dig0        <= w_dig0_next;
            r_dig1        <= w_dig1_next;
            r_ball        <= w_ball_next;
            r_timer       <= w_timer_next;
            r_graph_still <= w_graph_still_next;
            r_text_en     <= w_text_en_next;
        end
    end

    assign dig0        = r_dig0;
    assign dig1        = r_dig1;
    assign ball        = r_ball;
    assign graph_still = r_graph_still;
    assign text_en     = r_text_en;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Purpose  : Self-checking bench for pong_game_ctrl: directed game scenarios
//             plus randomized play against a score/ball/timer game model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int BALLS       = 3;
    localparam int TIMER_TICKS = 120;
`ifdef PONG_SCORE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int NG = 0;
    localparam int PL = 1;
    localparam int NB = 2;
    localparam int OV = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       refr_tick = 1'b0;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [1:0] ball;
    logic       graph_still;
    logic [3:0] text_en;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state, m_score, m_ball, m_timer;

    pong_game_ctrl #(.BALLS(BALLS), .TIMER_TICKS(TIMER_TICKS)) dut (
        .clk(clk), .reset_n(reset_n), .btn(btn), .hit(hit), .miss(miss),
        .refr_tick(refr_tick), .dig0(dig0), .dig1(dig1), .ball(ball),
        .graph_still(graph_still), .text_en(text_en)
    );

    always #5 clk = ~clk;

    // Game rules as plain integer arithmetic: score 0..99, balls, hold timer.
    function automatic void model_step(input logic [1:0] b, input logic h,
                                       input logic m, input logic t, input logic r);
        int t_next;
        if (!r) begin
            m_state = NG; m_score = 0; m_ball = BALLS; m_timer = 0;
            return;
        end
        t_next = (t && m_timer > 0) ? m_timer - 1 : m_timer;
        case (m_state)
            NG: if (b != 0) begin m_state = PL; m_score = 0; m_ball = BALLS; end
            PL: begin
                if (m) begin
                    m_ball  = m_ball - 1;
                    t_next  = TIMER_TICKS;
                    m_state = (m_ball == 0) ? OV : NB;
                end else if (h) begin
                    if (m_score == 99) m_score = SAT ? 99 : 0;
                    else m_score = m_score + 1;
                end
            end
            NB: if (m_timer == 0 && b != 0) m_state = PL;
            default: if (m_timer == 0) begin m_state = NG; m_ball = BALLS; end
        endcase
        m_timer = t_next;
    endfunction

    function automatic logic [14:0] model_vec();
        logic [3:0] te;
        te = (m_state == NG) ? 4'b1110 : (m_state == OV) ? 4'b1001 : 4'b1000;
        return {4'(m_score / 10), 4'(m_score % 10), 2'(m_ball), (m_state != PL), te};
    endfunction

    function automatic logic [14:0] vec(input int d1, input int d0, input int b,
                                        input logic gs, input logic [3:0] te);
        return {4'(d1), 4'(d0), 2'(b), gs, te};
    endfunction

    task automatic step(input logic [1:0] b, input logic h, input logic m,
                        input logic t, input logic r);
        btn = b; hit = h; miss = m; refr_tick = t; reset_n = r;
        @(posedge clk);
        model_step(b, h, m, t, r);
        #1;
        btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = vec(0, 0, 3, 1'b1, 4'b1110);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_start();
        logic [14:0] exp_v;
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = vec(0, 0, 3, 1'b0, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL start: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_score();
        logic [14:0] exp_v;
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
            step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        exp_v = vec(1, 0, 3, 1'b0, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL score_10: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        step(2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        exp_v = vec(1, 0, 2, 1'b1, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL hit_and_miss: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_newball_hold();
        logic [14:0] exp_v;
        for (int i = 0; i < TIMER_TICKS - 1; i++) step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_v = vec(1, 0, 2, 1'b1, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL hold_119: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL hold_120: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = vec(1, 0, 2, 1'b0, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL relaunch: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_game_over();
        logic [14:0] exp_v;
        step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < TIMER_TICKS; i++) step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = vec(1, 0, 1, 1'b0, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL last_ball: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_v = vec(1, 0, 0, 1'b1, 4'b1001);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL over_entry: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        for (int i = 0; i < TIMER_TICKS; i++) step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL over_hold: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = vec(1, 0, 3, 1'b1, 4'b1110);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL over_exit: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_wrap();
        logic [14:0] exp_v;
        step(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 99; i++) step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_v = vec(9, 9, 3, 1'b0, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL score_99: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_v = SAT ? vec(9, 9, 3, 1'b0, 4'b1000) : vec(0, 0, 3, 1'b0, 4'b1000);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL score_past_99: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp_v;
        step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < TIMER_TICKS - 50; i++) step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_v = vec(0, 0, 3, 1'b1, 4'b1110);
        n_checks++;
        if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", {dig1, dig0, ball, graph_still, text_en}, exp_v);
        end
    endtask

    task automatic test_random();
        logic [14:0] exp_v;
        logic [1:0]  b;
        logic        h, m, t, r;
        int          bad = 0;
        for (int i = 0; i < 6000; i++) begin
            b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            h = ($urandom_range(0, 2) == 0);
            m = ($urandom_range(0, 39) == 0);
            t = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 799) != 0);
            step(b, h, m, t, r);
            exp_v = model_vec();
            n_checks++;
            if ({dig1, dig0, ball, graph_still, text_en} !== exp_v) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle %0d: got %h expected %h", i,
                             {dig1, dig0, ball, graph_still, text_en}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_score();
        test_newball_hold();
        test_game_over();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the Pong display pipeline. It runs the new-game / play / new-ball / game-over state machine, owns the two-digit BCD score and the balls-remaining counter, and generates the region-enable mask that gates the text generator's four regions. It also drives the freeze signal for the ball/paddle graphics. It sits between the button inputs, the graphics block (hit/miss pulses), and the text generator (dig0, dig1, ball and region gating).

## Interface
- BALLS, 3: balls per game; legal range 1..3.
- TIMER_TICKS, 120: frame ticks of hold time in NEWBALL and OVER (2 s at 60 Hz); range 1..255.

- clk  in  1  system clock, pixel-domain clock shared with the text generator.
- reset_n  in  1  reset; one clock, reset is synchronous and active-low.
- btn  in  2  debounced paddle buttons, level; any bit high counts as a press.
- hit  in  1  one-cycle pulse from graphics: ball struck the paddle.
- miss  in  1  one-cycle pulse from graphics: ball passed the paddle.
- refr_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- dig0  out  4  score ones digit, BCD.
- dig1  out  4  score tens digit, BCD.
- ball  out  2  balls remaining, binary.
- graph_still  out  1  1 freezes the ball and paddles.
- text_en  out  4  region enables, ordered {score, logo, rule, over}; ANDed with the text generator's region flags.

## Operation
- States: NEWGAME, PLAY, NEWBALL, OVER. All outputs are registered.
- Reset values: state NEWGAME, dig1=0, dig0=0, ball=BALLS, timer=0, graph_still=1, text_en=4'b1110.
- text_en by state:
  - NEWGAME: 1110.
  - PLAY: 1000.
  - NEWBALL: 1000.
  - OVER: 1001.
- graph_still is 0 only in PLAY.
- NEWGAME -> PLAY when btn != 0. On this transition, score is cleared to 00 and ball is set to BALLS.
- PLAY, on hit with no miss: score increments in BCD. dig0 9 -> 0 carries into dig1. Behaviour at 99 is set under Configuration.
- PLAY, on miss:
  - If ball == 1: ball -> 0, timer -> TIMER_TICKS, next state OVER.
  - Otherwise: ball -> ball-1, timer -> TIMER_TICKS, next state NEWBALL.
- hit and miss in the same cycle: miss wins and the score is unchanged.
- hit and miss are ignored outside PLAY.
- NEWBALL -> PLAY when timer == 0 and btn != 0. A button held through the whole hold time relaunches on the first cycle timer reads 0.
- OVER -> NEWGAME when timer == 0. The score is kept so the final score stays visible in NEWGAME. ball reloads to BALLS on entry to NEWGAME.
- Timer: 8 bits. It decrements on refr_tick when nonzero, in any state, and never underflows.
- Timer load priority: a load on miss overrides a same-cycle refr_tick decrement.
- Reset asserted mid-game: all state returns to reset values on the next clk edge, regardless of pending pulses.

## Timing
- All decisions use the inputs sampled at a rising clk edge. The resulting state and outputs are visible after that edge, so latency is 1 cycle.
- The score, ball, state and text_en updates caused by one event appear together in the same cycle.
- Hold time: the timer reaches 0 exactly TIMER_TICKS refr_tick pulses after the miss edge. The exit transition happens at the first edge where timer == 0 and the exit condition holds.
- No handshakes: hit, miss and refr_tick are single-cycle pulses and are never stretched or queued.

## Configuration
- PONG_SCORE_SAT_EN:
  - Defined: score saturates at 99; further hits leave dig1=9, dig0=9.
  - Undefined: score wraps 99 -> 00 on the next hit.

## Test plan
- Reset, then btn=2'b01 for one cycle -> next cycle state PLAY, graph_still=0, text_en=1000, dig1/dig0=0/0, ball=3.
- In PLAY, 10 hit pulses -> dig1=1, dig0=0. Then hit and miss together -> score stays 10, ball=2, state NEWBALL.
- In NEWBALL with btn held, feed 119 refr_tick -> still NEWBALL. 120th tick -> timer=0; next edge -> PLAY.
- Third miss with ball=1 -> ball=0, state OVER, text_en=1001. After 120 ticks -> NEWGAME with ball=3, text_en=1110 and the score retained.
- Score at 99, then one hit -> 99 with PONG_SCORE_SAT_EN defined, 00 without.
- reset_n low for one cycle while in NEWBALL with timer=50 -> next cycle all outputs at reset values, timer=0.
